// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: buffers ALU operation requests in a small FIFO, drives the
// ALU operand/opcode registers, and returns checked results on a stream.
//
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   cmd_valid/ready     request stream; cmd_a, cmd_b, cmd_op payload
//   alu_a/alu_b/alu_sel registered ALU inputs
//   alu_out/alu_carry   registered ALU outputs (one cycle after issue)
//   rsp_valid/ready     response stream; rsp_result, rsp_carry, rsp_err
//   busy                FIFO non-empty or FSM not idle
//   rsp_count           responses delivered, wraps 255 -> 0
module alu_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy,
  output logic [7:0]       rsp_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Command FIFO storage and pointers (extra MSB tells full from empty)
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   wr_ptr_d;
  logic [AW:0]   rd_ptr_q;
  logic [AW:0]   rd_ptr_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  cmd_t          head;
  cmd_t          cmd_in;

  // FSM and issue/response registers
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_a_d;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] alu_b_d;
  logic [3:0]       alu_sel_q;
  logic [3:0]       alu_sel_d;
  logic             err_q;
  logic             err_d;
  logic             is_add_q;
  logic             is_add_d;
  logic             rsp_valid_q;
  logic             rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q;
  logic [WIDTH-1:0] rsp_result_d;
  logic             rsp_carry_q;
  logic             rsp_carry_d;
  logic             rsp_err_q;
  logic             rsp_err_d;
  logic [7:0]       rsp_count_q;
  logic [7:0]       rsp_count_d;
  logic             hs;
  logic             head_err;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign hs    = rsp_valid_q && rsp_ready;

  assign cmd_in.a  = cmd_a;
  assign cmd_in.b  = cmd_b;
  assign cmd_in.op = cmd_op;

  // Error class is decided at pop so capture needs no operand compare
  assign head_err = (head.op > 4'd3) ||
                    ((head.op == 4'd3) && (head.b == '0));

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = cmd_in;
    end
  end

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    err_d        = err_q;
    is_add_d     = is_add_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    rsp_count_d  = rsp_count_q;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_carry_d = is_add_q ? alu_carry : 1'b0;
        unique case (1'b1)
          err_q: begin
            rsp_result_d = {WIDTH{1'b1}};
            rsp_err_d    = 1'b1;
          end
          default: begin
            rsp_result_d = alu_out;
            rsp_err_d    = 1'b0;
          end
        endcase
        state_d = RESP;
      end
      RESP: begin
        if (hs) begin
          rsp_valid_d = 1'b0;
          rsp_count_d = rsp_count_q + 8'd1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A pop always loads the ALU inputs and the held check info
    if (pop) begin
      alu_a_d   = head.a;
      alu_b_d   = head.b;
      alu_sel_d = head.op;
      err_d     = head_err;
      is_add_d  = (head.op == 4'd0);
    end
  end

  // Storage is don't-care while empty, so it carries no reset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      err_q        <= 1'b0;
      is_add_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_count_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      err_q        <= err_d;
      is_add_q     <= is_add_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
      rsp_count_q  <= rsp_count_d;
    end
  end

  assign cmd_ready  = !full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_count  = rsp_count_q;
  assign busy       = !empty || (state_q != IDLE);

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side initiator for the 8-bit ALU. Accepts operation requests over a valid/ready stream and buffers them in a small FIFO. Issues each request to the ALU's A/B/ALU_Sel inputs, captures the registered ALU_Out/Carry_Out one cycle later, and returns a checked response over a second valid/ready stream. It sits between the sequencing/control logic and the ALU and owns all ALU operand timing.

## Interface
- DEPTH, 4, command FIFO depth in entries; power of two, ≥2
- WIDTH, 8, operand/result width; must match the ALU (8)
- clock  in  1  single clock; every register is updated on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock; the ALU shares this reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready at a rising edge
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_op  in  4  opcode: 0 add, 1 sub, 2 mul, 3 div; all other values illegal
- alu_a, alu_b  out  WIDTH  to ALU A, B; registered
- alu_sel  out  4  to ALU ALU_Sel; registered
- alu_out  in  WIDTH  from ALU ALU_Out
- alu_carry  in  1  from ALU Carry_Out
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge
- rsp_result  out  WIDTH  result
- rsp_carry  out  1  carry; meaningful for add only
- rsp_err  out  1  divide-by-zero or illegal opcode
- busy  out  1  high when FIFO is non-empty or state ≠ IDLE
- rsp_count  out  8  responses delivered; wraps 255→0

## Operation
- **FIFO**
  - cmd_ready = !full.
  - Push and pop in the same cycle are both honoured.
  - No bypass: a command always passes through the FIFO.
- **FSM states: IDLE, ISSUE, WAIT, RESP.**
  - IDLE: if FIFO non-empty, pop head, load alu_a/alu_b/alu_sel, → ISSUE.
  - ISSUE: unconditional → WAIT. The ALU registers its result at this edge.
  - WAIT: capture the response into the rsp_* registers, set rsp_valid, → RESP.
  - RESP: hold every rsp_* output stable until the handshake. On the handshake edge:
    - if FIFO non-empty: pop, load alu_*, → ISSUE;
    - otherwise → IDLE.
- **Response capture (WAIT)**
  - Divide-by-zero (op=3, b=0): rsp_result=8'hFF, rsp_err=1.
  - Illegal op (op>3): rsp_result=8'hFF, rsp_err=1.
  - Otherwise: rsp_result=alu_out, rsp_err=0.
  - rsp_carry = alu_carry when op=0; 0 for every other op.
- **Hold behaviour**
  - alu_* hold their last issued value outside ISSUE.
  - The opcode/operands needed for the error check are held in internal registers from pop until capture.
- **Arithmetic.** All results are modulo 2^WIDTH, exactly as returned by the ALU. No checking is done beyond the error rules above.
- **rsp_count** increments by 1 on each response handshake; 8'hFF → 8'h00.

## Timing
- **Reset values:** cmd_ready=1 (FIFO empty); alu_a=0, alu_b=0, alu_sel=0; rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_err=0; busy=0; rsp_count=0; state IDLE; FIFO empty.
- **Latency with an idle FSM:** command accepted at edge E0 → popped at E1 (alu_* valid after E1) → ALU registers at E2 → rsp_valid high after E3.
- **Throughput:** one response per 3 cycles when rsp_ready is held high.
- **Back-pressure:** rsp_ready low stalls the FSM in RESP. The FIFO continues to accept until full. With DEPTH=4, 5 commands are accepted in total (1 in flight + 4 buffered).
- **Reset mid-operation** (any state): at the reset edge
  - the FIFO is flushed and the FSM returns to IDLE;
  - any in-flight or pending response is dropped;
  - every output returns to its reset value on the next cycle.
- cmd_valid asserted during reset is ignored.

## Test plan
- ADD a=200, b=100, rsp_ready=1 → rsp_result=0x2C, rsp_carry=1, rsp_err=0; rsp_valid high exactly 3 cycles after accept; rsp_count=1.
- SUB 5−7, then MUL 16×17, then DIV 200/7 back-to-back → results 0xFE, 0x10, 0x1C in order; carry=0 and err=0 on all three; responses 3 cycles apart.
- DIV a=7, b=0, then op=4'b0101 a=1, b=1 → both responses rsp_result=0xFF, rsp_err=1, rsp_carry=0.
- rsp_ready=0 with 6 commands offered back-to-back → 5 accepted; cmd_ready low after the 5th; first response held stable. Releasing rsp_ready drains all 5 in order.
- Reset asserted for 1 cycle while in WAIT with 2 commands queued → rsp_valid stays 0; busy=0, cmd_ready=1, rsp_count=0 next cycle; no stale response ever emerges.
- 256 ADD commands with rsp_ready=1 → rsp_count wraps to 0 after the 256th handshake.
